vga_timing_rx: RTL and testbench

// Receive end of the ogege VGA pixel interface: samples an incoming 12-bit RGB + hsync/vsync/de

---
 rtl/vga_timing_rx.sv | 207 ++++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// Receive side of the VGA pixel interface: registers the incoming stream, measures line/frame
// timing, locks after consistent frames and re-emits active pixels with recovered coordinates.
module vga_timing_rx #(
    parameter int HSZ         = 10,
    parameter int VSZ         = 10,
    parameter int HTSZ        = 11,
    parameter int VTSZ        = 11,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [3:0]      i_r,
    input  logic [3:0]      i_g,
    input  logic [3:0]      i_b,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_de,
    output logic [11:0]     o_color,
    output logic [HSZ-1:0]  o_hcount,
    output logic [VSZ-1:0]  o_vcount,
    output logic            o_valid,
    output logic            o_locked,
    output logic [HTSZ-1:0] o_line_clks,
    output logic [HSZ:0]    o_act_pix,
    output logic [VSZ:0]    o_act_lines,
    output logic            o_err
);

    localparam int MCW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t state, state_next;

    logic [11:0]     s1_color;
    logic            s1_hs, s1_vs, s1_de, p_hs, p_vs;
    logic [HTSZ-1:0] line_clk, ref_clks, prev_clks;
    logic [HSZ:0]    pix, ref_pix, prev_pix;
    logic [VSZ:0]    line_idx, prev_lines;
    logic [VTSZ-1:0] frame_lines;
    logic            seen_hs, ref_clks_vld, ref_pix_vld, frame_bad, prev_vld;
    logic [MCW-1:0]  match_cnt;

    logic            hs_edge, vs_edge, close, de_in, had_de;
    logic            sat_mm, clk_mm, pix_mm, line_mm, frame_ok, reach;
    logic            lock_lost, valid_next;
    logic [HTSZ-1:0] line_len, line_clk_next, ref_clks_a;
    logic [HSZ:0]    pix_cur, pix_next, ref_pix_a;
    logic [VSZ:0]    line_idx_a, line_idx_cur;
    logic [VTSZ-1:0] frame_lines_a;
    logic            ref_clks_vld_a, ref_pix_vld_a, frame_bad_a;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_color <= '0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
            p_hs     <= 1'b0;
            p_vs     <= 1'b0;
        end else begin
            s1_color <= {i_r, i_g, i_b};
            s1_hs    <= i_hsync;
            s1_vs    <= i_vsync;
            s1_de    <= i_de;
            p_hs     <= s1_hs;
            p_vs     <= s1_vs;
        end
    end

    assign hs_edge = (s1_hs == HS_POL) && (p_hs != HS_POL);
    assign vs_edge = (s1_vs == VS_POL) && (p_vs != VS_POL);

    // The "_a" values are the frame state after the current line closes; a simultaneous
    // vsync edge then closes the frame using them before the new frame starts.
    always_comb begin
        close          = hs_edge && seen_hs;
        de_in          = s1_de && (seen_hs || hs_edge);
        had_de         = (pix != '0);
        line_len       = (line_clk == '1) ? line_clk : line_clk + 1'b1;
        line_clk_next  = hs_edge ? '0 : line_len;
        pix_cur        = hs_edge ? '0 : pix;
        pix_next       = (de_in && pix_cur != '1) ? pix_cur + 1'b1 : pix_cur;
        sat_mm         = seen_hs && ((line_clk == '1) ||
                                     (de_in && pix_cur == '1) ||
                                     (close && had_de && line_idx == '1) ||
                                     (close && frame_lines == '1));
        clk_mm         = close && ref_clks_vld && (line_len != ref_clks);
        pix_mm         = close && had_de && ref_pix_vld && (pix != ref_pix);
        line_mm        = sat_mm || clk_mm || pix_mm;
        ref_clks_a     = (close && !ref_clks_vld) ? line_len : ref_clks;
        ref_clks_vld_a = ref_clks_vld || close;
        ref_pix_a      = (close && had_de && !ref_pix_vld) ? pix : ref_pix;
        ref_pix_vld_a  = ref_pix_vld || (close && had_de);
        line_idx_a     = (close && had_de && line_idx != '1) ? line_idx + 1'b1 : line_idx;
        frame_lines_a  = (close && frame_lines != '1) ? frame_lines + 1'b1 : frame_lines;
        frame_bad_a    = frame_bad || line_mm;
        line_idx_cur   = vs_edge ? '0 : line_idx_a;
        frame_ok       = !frame_bad_a && ref_clks_vld_a &&
                         (!prev_vld || (ref_clks_a == prev_clks &&
                                        ref_pix_a  == prev_pix  &&
                                        line_idx_a == prev_lines));
        reach          = ((match_cnt + 1'b1) == MCW'(LOCK_FRAMES));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= SEARCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (vs_edge) state_next = MEASURE;
            MEASURE: if (vs_edge && frame_ok && reach) state_next = LOCKED;
            LOCKED:  if (line_mm || (vs_edge && !frame_ok)) state_next = MEASURE;
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        o_locked   = (state == LOCKED);
        lock_lost  = (state == LOCKED) && (line_mm || (vs_edge && !frame_ok));
        o_err      = lock_lost;
        valid_next = (state == LOCKED) && de_in;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            line_clk     <= '0;
            pix          <= '0;
            line_idx     <= '0;
            frame_lines  <= '0;
            seen_hs      <= 1'b0;
            ref_clks     <= '0;
            ref_clks_vld <= 1'b0;
            ref_pix      <= '0;
            ref_pix_vld  <= 1'b0;
            frame_bad    <= 1'b0;
            prev_clks    <= '0;
            prev_pix     <= '0;
            prev_lines   <= '0;
            prev_vld     <= 1'b0;
            match_cnt    <= '0;
            o_line_clks  <= '0;
            o_act_pix    <= '0;
            o_act_lines  <= '0;
        end else begin
            line_clk <= line_clk_next;
            pix      <= pix_next;
            line_idx <= line_idx_cur;
            seen_hs  <= seen_hs || hs_edge;
            ref_clks <= ref_clks_a;
            ref_pix  <= ref_pix_a;
            if (vs_edge) begin
                frame_lines  <= '0;
                ref_clks_vld <= 1'b0;
                ref_pix_vld  <= 1'b0;
                frame_bad    <= 1'b0;
                if (state == SEARCH) begin
                    prev_vld <= 1'b0;
                end else begin
                    prev_clks  <= ref_clks_a;
                    prev_pix   <= ref_pix_a;
                    prev_lines <= line_idx_a;
                    prev_vld   <= 1'b1;
                end
            end else begin
                frame_lines  <= frame_lines_a;
                ref_clks_vld <= ref_clks_vld_a;
                ref_pix_vld  <= ref_pix_vld_a;
                frame_bad    <= frame_bad_a;
            end
            case (state)
                SEARCH:  if (vs_edge) match_cnt <= '0;
                MEASURE: if (vs_edge) match_cnt <= (frame_ok && !reach) ? match_cnt + 1'b1 : '0;
                LOCKED:  if (lock_lost) match_cnt <= '0;
                default: match_cnt <= '0;
            endcase
            if (state == MEASURE && state_next == LOCKED) begin
                o_line_clks <= ref_clks_a;
                o_act_pix   <= ref_pix_a;
                o_act_lines <= line_idx_a;
            end
        end
    end

    // Pixel outputs hold their last value whenever the pixel is not valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            o_color  <= '0;
            o_hcount <= '0;
            o_vcount <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= valid_next;
            if (valid_next) begin
                o_color  <= s1_color;
                o_hcount <= pix_cur[HSZ-1:0];
                o_vcount <= line_idx_cur[VSZ-1:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled raster: 20 clocks/line, 12 active pixels,
// 10 lines/frame, 6 active lines, active-low syncs.
module tb_vga_timing_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  r, g, b;
    logic        hs, vs, de;
    logic [11:0] o_color;
    logic [9:0]  o_hcount;
    logic [9:0]  o_vcount;
    logic        o_valid, o_locked, o_err;
    logic [10:0] o_line_clks;
    logic [10:0] o_act_pix;
    logic [10:0] o_act_lines;

    int          checks = 0;
    int          failures = 0;
    int          err_pulses = 0;
    bit          probe_on = 1'b0;
    int          probe_stage = 0;
    int          probe_x, probe_y;
    logic [11:0] probe_col, probe_prev;

    vga_timing_rx dut (
        .clk_i       (clk),
        .rstn_i      (rst_n),
        .i_r         (r),
        .i_g         (g),
        .i_b         (b),
        .i_hsync     (hs),
        .i_vsync     (vs),
        .i_de        (de),
        .o_color     (o_color),
        .o_hcount    (o_hcount),
        .o_vcount    (o_vcount),
        .o_valid     (o_valid),
        .o_locked    (o_locked),
        .o_line_clks (o_line_clks),
        .o_act_pix   (o_act_pix),
        .o_act_lines (o_act_lines),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pixColor(input int h, input int v);
        logic [3:0] hh, vv;
        hh = h[3:0];
        vv = v[3:0];
        return {hh, vv, 4'h3};
    endfunction

    task automatic applyStimulus(input logic hs_v, input logic vs_v, input logic de_v,
                                 input logic [11:0] col);
        hs = hs_v;
        vs = vs_v;
        de = de_v;
        {r, g, b} = col;
        @(posedge clk);
        #1;
        if (o_err === 1'b1) err_pulses++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame starting at line 0; vsync asserts at column vsh of line 7 for two lines.
    task automatic sendFrame(input int vsh, input int short_line);
        logic [11:0] col;
        logic        vs_act;
        bit          hit;
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 20; h++) begin
                if (v == short_line && h == 19) continue;
                vs_act = (v == 7 && h >= vsh) || (v == 8) || (v == 9 && h < vsh);
                col    = pixColor(h, v);
                hit    = probe_on && (h == probe_x) && (v == probe_y);
                if (hit) col = probe_col;
                applyStimulus(!(h >= 14 && h < 16), !vs_act, (h < 12 && v < 6), col);
                if (probe_stage == 1) begin
                    checkOutput("probe_valid",  32'(o_valid),  32'd1);
                    checkOutput("probe_hcount", 32'(o_hcount), 32'(probe_x));
                    checkOutput("probe_vcount", 32'(o_vcount), 32'(probe_y));
                    checkOutput("probe_color",  32'(o_color),  32'(probe_col));
                    probe_stage = 0;
                end
                if (hit) begin
                    checkOutput("probe_one_clk_hold", 32'(o_color), 32'(probe_prev));
                    probe_stage = 1;
                    probe_on    = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; de = 1'b0; {r, g, b} = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid",     32'(o_valid),     32'd0);
        checkOutput("rst_locked",    32'(o_locked),    32'd0);
        checkOutput("rst_err",       32'(o_err),       32'd0);
        checkOutput("rst_color",     32'(o_color),     32'd0);
        checkOutput("rst_line_clks", 32'(o_line_clks), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] initial lock");
        sendFrame(2, -1);
        sendFrame(2, -1);
        checkOutput("no_lock_before_3rd_edge", 32'(o_locked), 32'd0);
        checkOutput("no_err_while_measuring",  32'(err_pulses), 32'd0);
        sendFrame(2, -1);
        checkOutput("lock_at_3rd_edge", 32'(o_locked),    32'd1);
        checkOutput("line_clks",        32'(o_line_clks), 32'd20);
        checkOutput("act_pix",          32'(o_act_pix),   32'd12);
        checkOutput("act_lines",        32'(o_act_lines), 32'd6);

        $display("[TB] pixel pass-through");
        probe_x = 5; probe_y = 3; probe_col = 12'hA5C; probe_prev = 12'h433; probe_on = 1'b1;
        sendFrame(2, -1);

        $display("[TB] coincident hsync/vsync edges");
        err_pulses = 0;
        sendFrame(14, -1);
        probe_x = 0; probe_y = 0; probe_col = 12'h1E7; probe_prev = 12'hB53; probe_on = 1'b1;
        sendFrame(2, -1);
        checkOutput("lock_kept_coincident", 32'(o_locked),   32'd1);
        checkOutput("no_err_coincident",    32'(err_pulses), 32'd0);

        $display("[TB] short line");
        err_pulses = 0;
        sendFrame(2, 2);
        checkOutput("short_line_err_pulses", 32'(err_pulses),  32'd1);
        checkOutput("short_line_unlock",     32'(o_locked),    32'd0);
        checkOutput("line_clks_held",        32'(o_line_clks), 32'd20);
        sendFrame(2, -1);
        checkOutput("no_relock_1_clean", 32'(o_locked), 32'd0);
        sendFrame(2, -1);
        checkOutput("relock_2_clean",    32'(o_locked), 32'd1);

        $display("[TB] saturation");
        err_pulses = 0;
        for (int i = 0; i < 2100; i++) applyStimulus(1'b1, 1'b1, 1'b1, 12'h000);
        checkOutput("sat_err_pulses", 32'(err_pulses), 32'd1);
        checkOutput("sat_unlock",     32'(o_locked),   32'd0);
        sendFrame(2, -1);
        sendFrame(2, -1);
        sendFrame(2, -1);
        checkOutput("sat_no_lock", 32'(o_locked), 32'd0);
        sendFrame(2, -1);
        checkOutput("sat_relock",  32'(o_locked), 32'd1);

        $display("[TB] reset mid-stream");
        for (int h = 0; h < 8; h++) applyStimulus(1'b1, 1'b1, 1'b1, pixColor(h, 0));
        checkOutput("pre_rst_valid",  32'(o_valid),  32'd1);
        checkOutput("pre_rst_hcount", 32'(o_hcount), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid",     32'(o_valid),     32'd0);
        checkOutput("async_rst_hcount",    32'(o_hcount),    32'd0);
        checkOutput("async_rst_color",     32'(o_color),     32'd0);
        checkOutput("async_rst_locked",    32'(o_locked),    32'd0);
        checkOutput("async_rst_act_lines", 32'(o_act_lines), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(2, -1);
        sendFrame(2, -1);
        checkOutput("post_rst_no_lock", 32'(o_locked), 32'd0);
        sendFrame(2, -1);
        checkOutput("post_rst_lock",      32'(o_locked),    32'd1);
        checkOutput("post_rst_act_lines", 32'(o_act_lines), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
